// File: rtl/rs232out_fifo_if.sv
// Producer-side byte FIFO signals plus the serial-transmitter handshake.
// master drives writes and tx_busy; slave is the FIFO/transmit sequencer.
interface rs232out_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  clr_ovf;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic [7:0]            tx_data;
    logic                  tx_we;
    logic                  tx_busy;

    modport master (
        output wr_en, wr_data, clr_ovf, tx_busy,
        input  full, empty, count, overflow, tx_data, tx_we
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_busy,
        output full, empty, count, overflow, tx_data, tx_we
    );
endinterface

// File: rtl/rs232out_fifo.sv
// Byte FIFO feeding a serial transmitter one byte at a time; first tx_we two cycles after a write into an idle FIFO.
// Writes to a full FIFO are dropped and flagged; pops stall while tx_busy is high or a byte is in flight.
module rs232out_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int BUSY_WAIT  = 2
) (
    input  logic              clk25MHz,
    input  logic              reset_n,
    rs232out_fifo_if.slave    bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int WCW   = (BUSY_WAIT < 2) ? 1 : $clog2(BUSY_WAIT + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    localparam logic [DEPTH_LOG2:0] CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [WCW-1:0]      WAIT_INIT = WCW'(BUSY_WAIT);
    localparam logic [WCW-1:0]      WAIT_ONE  = WCW'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic                  ovf;
    logic [1:0]            state;
    logic [WCW-1:0]        wait_cnt;
    logic                  tx_we_q;
    logic [7:0]            tx_data_q;

    logic is_full;
    logic is_empty;
    logic push;
    logic pop;
    logic drop;

    always_comb begin
        is_full  = (cnt == CNT_FULL);
        is_empty = (cnt == '0);
        push     = bus.wr_en && !is_full;
        drop     = bus.wr_en && is_full;
        // Only IDLE pops, so at most one byte is ever handed to the transmitter.
        pop      = (state == S_IDLE) && !is_empty && !bus.tx_busy;
    end

    always_ff @(posedge clk25MHz) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk25MHz) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // A dropped write outranks a simultaneous clear.
            if (drop) begin
                ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk25MHz) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            tx_we_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_we_q <= 1'b0;
                    if (pop) begin
                        tx_data_q <= mem[rd_ptr];
                        tx_we_q   <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tx_we_q  <= 1'b0;
                    wait_cnt <= WAIT_INIT;
                    state    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    tx_we_q <= 1'b0;
                    // A transmitter that never acknowledges must not hang the queue.
                    if (bus.tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (wait_cnt <= WAIT_ONE) begin
                        wait_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    tx_we_q <= 1'b0;
                    if (!bus.tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    tx_we_q <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.full     = is_full;
    assign bus.empty    = is_empty;
    assign bus.count    = cnt;
    assign bus.overflow = ovf;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_we    = tx_we_q;

    a_we_single: assert property (@(posedge clk25MHz) disable iff (!reset_n)
        tx_we_q |=> !tx_we_q);
    a_cnt_range: assert property (@(posedge clk25MHz) disable iff (!reset_n)
        cnt <= CNT_FULL);
endmodule

// File: tb/tb_rs232out_fifo.sv
// Directed bench for rs232out_fifo: latency, full/overflow, busy timeout, wrap, reset and clr_ovf.
module tb_rs232out_fifo;
    logic clk25MHz = 1'b0;
    logic reset_n  = 1'b0;

    always #20 clk25MHz = ~clk25MHz;

    rs232out_fifo_if #(.DEPTH_LOG2(4)) bus();

    rs232out_fifo #(.DEPTH_LOG2(4), .BUSY_WAIT(2)) dut (
        .clk25MHz (clk25MHz),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd2;
    localparam logic [1:0] ST_WD   = 2'd3;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] txq [$];
    logic       prev_we     = 1'b0;

    // Transmitted-byte capture; tx_we must never be high two cycles running.
    always @(negedge clk25MHz) begin
        if (bus.tx_we === 1'b1) begin
            txq.push_back(bus.tx_data);
            vectors++;
            if (prev_we) begin
                miscompares++;
                $display("FAIL tx_we_consecutive: tx_we=1 twice in a row, required single-cycle pulse");
            end
        end
        prev_we = (bus.tx_we === 1'b1);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded 1ms, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk25MHz);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.clr_ovf = 1'b0;
        bus.tx_busy = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        txq.delete();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.count, bus.empty, bus.full, bus.overflow, bus.tx_we, bus.tx_data, dut.state}
            !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, ST_IDLE}) begin
            miscompares++;
            $display("FAIL reset_state: cnt=%0d empty=%b full=%b ovf=%b we=%b data=%h st=%0d, required 0 1 0 0 0 00 0",
                     bus.count, bus.empty, bus.full, bus.overflow, bus.tx_we, bus.tx_data, dut.state);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.wr_en = 1'b1; bus.wr_data = 8'h41;
        tick();
        bus.wr_en = 1'b0;
        vectors++;
        if ({bus.count, bus.tx_we} !== {5'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL single_accept: cnt=%0d we=%b, required 1 0", bus.count, bus.tx_we);
        end
        tick();
        vectors++;
        if ({bus.tx_we, bus.tx_data, bus.count} !== {1'b1, 8'h41, 5'd0}) begin
            miscompares++;
            $display("FAIL single_issue: we=%b data=%h cnt=%0d, required 1 41 0", bus.tx_we, bus.tx_data, bus.count);
        end
        tick();
        vectors++;
        if ({bus.tx_we, dut.state} !== {1'b0, ST_WB}) begin
            miscompares++;
            $display("FAIL single_wait_busy: we=%b st=%0d, required 0 2", bus.tx_we, dut.state);
        end
        bus.tx_busy = 1'b1;
        repeat (10) tick();
        vectors++;
        if ({dut.state, bus.tx_data, bus.tx_we} !== {ST_WD, 8'h41, 1'b0}) begin
            miscompares++;
            $display("FAIL single_wait_done: st=%0d data=%h we=%b, required 3 41 0", dut.state, bus.tx_data, bus.tx_we);
        end
        bus.tx_busy = 1'b0;
        tick();
        vectors++;
        if ({dut.state, bus.count, bus.empty} !== {ST_IDLE, 5'd0, 1'b1} || txq.size() != 1) begin
            miscompares++;
            $display("FAIL single_done: st=%0d cnt=%0d empty=%b sent=%0d, required 0 0 1 1",
                     dut.state, bus.count, bus.empty, txq.size());
        end
    endtask

    task automatic test_no_busy();
        do_reset();
        bus.wr_en = 1'b1; bus.wr_data = 8'hA1;
        tick();
        bus.wr_data = 8'hA2;
        tick();
        bus.wr_en = 1'b0;
        vectors++;
        if ({bus.tx_we, bus.tx_data, bus.count} !== {1'b1, 8'hA1, 5'd1}) begin
            miscompares++;
            $display("FAIL nobusy_issue1: we=%b data=%h cnt=%0d, required 1 a1 1", bus.tx_we, bus.tx_data, bus.count);
        end
        tick();
        tick();
        vectors++;
        if ({dut.state, bus.tx_we} !== {ST_WB, 1'b0}) begin
            miscompares++;
            $display("FAIL nobusy_waiting: st=%0d we=%b, required 2 0", dut.state, bus.tx_we);
        end
        tick();
        vectors++;
        if ({dut.state, bus.tx_we} !== {ST_IDLE, 1'b0}) begin
            miscompares++;
            $display("FAIL nobusy_timeout: st=%0d we=%b, required 0 0", dut.state, bus.tx_we);
        end
        tick();
        vectors++;
        if ({bus.tx_we, bus.tx_data, bus.count} !== {1'b1, 8'hA2, 5'd0}) begin
            miscompares++;
            $display("FAIL nobusy_issue2: we=%b data=%h cnt=%0d, required 1 a2 0", bus.tx_we, bus.tx_data, bus.count);
        end
        repeat (6) tick();
        vectors++;
        if (txq.size() != 2 || dut.state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL nobusy_sent: sent=%0d st=%0d, required 2 0", txq.size(), dut.state);
        end
    endtask

    task automatic test_burst();
        do_reset();
        bus.tx_busy = 1'b1;
        bus.wr_en   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wr_data = 8'(i);
            tick();
        end
        vectors++;
        if ({bus.count, bus.full, bus.empty, bus.overflow} !== {5'd16, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL burst_full: cnt=%0d full=%b empty=%b ovf=%b, required 16 1 0 0",
                     bus.count, bus.full, bus.empty, bus.overflow);
        end
        bus.wr_data = 8'h10;
        tick();
        bus.wr_en = 1'b0;
        vectors++;
        if ({bus.count, bus.overflow, bus.tx_we} !== {5'd16, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL burst_drop: cnt=%0d ovf=%b we=%b, required 16 1 0", bus.count, bus.overflow, bus.tx_we);
        end
        bus.tx_busy = 1'b0;
        repeat (80) tick();
        vectors++;
        if (txq.size() != 16 || bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL burst_drain: sent=%0d empty=%b ovf=%b, required 16 1 1", txq.size(), bus.empty, bus.overflow);
        end
        for (int i = 0; i < 16 && i < txq.size(); i++) begin
            vectors++;
            if (txq[i] !== 8'(i)) begin
                miscompares++;
                $display("FAIL burst_order[%0d]: got %h, required %h", i, txq[i], 8'(i));
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            bus.wr_data = 8'h50 + 8'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        repeat (60) tick();
        vectors++;
        if ({bus.count, dut.wr_ptr, dut.rd_ptr} !== {5'd0, 4'd11, 4'd11}) begin
            miscompares++;
            $display("FAIL wrap_prefill: cnt=%0d wp=%0d rp=%0d, required 0 11 11", bus.count, dut.wr_ptr, dut.rd_ptr);
        end
        txq.delete();
        bus.tx_busy = 1'b1;
        bus.wr_en   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.wr_data = 8'h60 + 8'(i);
            tick();
        end
        vectors++;
        if ({bus.count, dut.wr_ptr, dut.rd_ptr} !== {5'd5, 4'd0, 4'd11}) begin
            miscompares++;
            $display("FAIL wrap_wp: cnt=%0d wp=%0d rp=%0d, required 5 0 11", bus.count, dut.wr_ptr, dut.rd_ptr);
        end
        bus.tx_busy = 1'b0;
        bus.wr_data = 8'h65;
        tick();
        bus.wr_en = 1'b0;
        vectors++;
        if ({bus.count, bus.tx_we, bus.tx_data, dut.wr_ptr, dut.rd_ptr} !== {5'd5, 1'b1, 8'h60, 4'd1, 4'd12}) begin
            miscompares++;
            $display("FAIL wrap_push_pop: cnt=%0d we=%b data=%h wp=%0d rp=%0d, required 5 1 60 1 12",
                     bus.count, bus.tx_we, bus.tx_data, dut.wr_ptr, dut.rd_ptr);
        end
        repeat (40) tick();
        vectors++;
        if (txq.size() != 6 || {bus.count, dut.rd_ptr} !== {5'd0, 4'd1}) begin
            miscompares++;
            $display("FAIL wrap_drain: sent=%0d cnt=%0d rp=%0d, required 6 0 1", txq.size(), bus.count, dut.rd_ptr);
        end
        for (int i = 0; i < 6 && i < txq.size(); i++) begin
            vectors++;
            if (txq[i] !== 8'h60 + 8'(i)) begin
                miscompares++;
                $display("FAIL wrap_order[%0d]: got %h, required %h", i, txq[i], 8'h60 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_data = 8'hC0 + 8'(i);
            tick();
        end
        bus.wr_en   = 1'b0;
        bus.tx_busy = 1'b1;
        tick();
        vectors++;
        if ({dut.state, bus.count} !== {ST_WD, 5'd3}) begin
            miscompares++;
            $display("FAIL rstmid_setup: st=%0d cnt=%0d, required 3 3", dut.state, bus.count);
        end
        reset_n = 1'b0;
        tick();
        reset_n     = 1'b1;
        bus.tx_busy = 1'b0;
        vectors++;
        if ({bus.count, bus.empty, bus.full, bus.overflow, bus.tx_we, bus.tx_data, dut.state, dut.wr_ptr, dut.rd_ptr}
            !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, ST_IDLE, 4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL rstmid_state: cnt=%0d empty=%b ovf=%b we=%b data=%h st=%0d wp=%0d rp=%0d, required 0 1 0 0 00 0 0 0",
                     bus.count, bus.empty, bus.overflow, bus.tx_we, bus.tx_data, dut.state, dut.wr_ptr, dut.rd_ptr);
        end
        txq.delete();
        repeat (10) tick();
        vectors++;
        if (txq.size() != 0) begin
            miscompares++;
            $display("FAIL rstmid_quiet: sent=%0d after reset, required 0", txq.size());
        end
        bus.wr_en = 1'b1; bus.wr_data = 8'hC9;
        tick();
        bus.wr_en = 1'b0;
        tick();
        vectors++;
        if ({bus.tx_we, bus.tx_data} !== {1'b1, 8'hC9}) begin
            miscompares++;
            $display("FAIL rstmid_new: we=%b data=%h, required 1 c9", bus.tx_we, bus.tx_data);
        end
    endtask

    task automatic test_ovf_clr();
        do_reset();
        bus.tx_busy = 1'b1;
        bus.wr_en   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wr_data = 8'h70 + 8'(i);
            tick();
        end
        bus.wr_data = 8'h80;
        tick();
        vectors++;
        if (bus.overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set: ovf=%b, required 1", bus.overflow);
        end
        bus.clr_ovf = 1'b1;
        bus.wr_data = 8'h81;
        tick();
        vectors++;
        if (bus.overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set_wins: ovf=%b, required 1", bus.overflow);
        end
        bus.wr_en = 1'b0;
        tick();
        bus.clr_ovf = 1'b0;
        vectors++;
        if (bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: ovf=%b, required 0", bus.overflow);
        end
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h82;
        bus.tx_busy = 1'b0;
        tick();
        bus.wr_en = 1'b0;
        vectors++;
        if ({bus.overflow, bus.count, bus.tx_we, bus.tx_data} !== {1'b1, 5'd15, 1'b1, 8'h70}) begin
            miscompares++;
            $display("FAIL ovf_drop_with_pop: ovf=%b cnt=%0d we=%b data=%h, required 1 15 1 70",
                     bus.overflow, bus.count, bus.tx_we, bus.tx_data);
        end
        repeat (80) tick();
        vectors++;
        if (txq.size() != 16 || bus.count !== 5'd0) begin
            miscompares++;
            $display("FAIL ovf_drain: sent=%0d cnt=%0d, required 16 0", txq.size(), bus.count);
        end
        for (int i = 0; i < 16 && i < txq.size(); i++) begin
            vectors++;
            if (txq[i] !== 8'h70 + 8'(i)) begin
                miscompares++;
                $display("FAIL ovf_order[%0d]: got %h, required %h", i, txq[i], 8'h70 + 8'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_no_busy();
        test_burst();
        test_wrap();
        test_reset_mid();
        test_ovf_clr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rs232out_fifo.md
RS232OUT_FIFO -- requirements
Module: rs232out_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, SHALL set FIFO depth to 2**DEPTH_LOG2 bytes.
REQ-002 Parameter BUSY_WAIT, default 2, SHALL set the max cycles to wait for tx_busy to rise after a tx_we pulse.
REQ-003 clk25MHz  in  1  clock; all logic SHALL be on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 wr_en  in  1  producer byte write strobe, sampled each cycle.
REQ-006 wr_data  in  8  byte to enqueue when wr_en=1.
REQ-007 clr_ovf  in  1  clears the sticky overflow flag.
REQ-008 full  out  1  SHALL be 1 when count = 2**DEPTH_LOG2.
REQ-009 empty  out  1  SHALL be 1 when count = 0.
REQ-010 count  out  DEPTH_LOG2+1  bytes currently stored.
REQ-011 overflow  out  1  sticky; a write was dropped.
REQ-012 tx_data  out  8  byte presented to the serial transmitter, registered.
REQ-013 tx_we  out  1  one-cycle transmit strobe to the serial transmitter, registered.
REQ-014 tx_busy  in  1  transmitter busy from the serial transmitter.

Function
REQ-015 Storage SHALL be a circular buffer with wr_ptr and rd_ptr of DEPTH_LOG2 bits each, wrapping modulo 2**DEPTH_LOG2.
REQ-016 A write with wr_en=1 and full=0 SHALL store wr_data at wr_ptr, advance wr_ptr and increment count at that edge.
REQ-017 A write with wr_en=1 and full=1 SHALL be dropped and set overflow=1, even when a pop occurs in the same cycle.
REQ-018 A simultaneous accepted write and pop SHALL leave count unchanged.
REQ-019 clr_ovf=1 SHALL clear overflow at the next edge; if a dropped write occurs in the same cycle, overflow SHALL end at 1 (set wins).
REQ-020 The transmit FSM SHALL have states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-021 IDLE: if count!=0 and tx_busy=0, the FSM SHALL pop the head byte into tx_data, assert tx_we for the next cycle and go to ISSUE.
REQ-022 ISSUE: the FSM SHALL deassert tx_we, load the wait counter with BUSY_WAIT and go to WAIT_BUSY.
REQ-023 WAIT_BUSY: on tx_busy=1 the FSM SHALL go to WAIT_DONE; otherwise it SHALL decrement the wait counter, and on reaching 0 SHALL go to IDLE.
REQ-024 WAIT_DONE: the FSM SHALL stay while tx_busy=1 and go to IDLE when tx_busy=0.
REQ-025 tx_we SHALL be high for exactly one cycle per popped byte, and never high in two consecutive cycles.
REQ-026 tx_data SHALL be held stable from the tx_we cycle until the next pop.
REQ-027 Latency: a write accepted at edge N into an empty FIFO, with FSM in IDLE and tx_busy=0, SHALL produce tx_we=1 in the cycle following edge N+1.
REQ-028 Bytes SHALL be transmitted in write order with no loss or duplication, except bytes dropped under REQ-017.
REQ-029 A pop SHALL occur only in IDLE, so at most one byte is in flight at any time.

Reset
REQ-030 While reset_n=0 at an edge, the block SHALL set wr_ptr=0, rd_ptr=0, count=0, overflow=0, tx_we=0, tx_data=0 and FSM=IDLE.
REQ-031 Reset mid-transmission SHALL discard all stored bytes; the block SHALL NOT re-issue tx_we after reset until a new write arrives.
REQ-032 Buffer memory contents SHALL NOT require reset.

Verification
REQ-033 Write 0x41 to the empty FIFO, with tx_busy raised 1 cycle after tx_we and held for 10 cycles -> tx_we=1 two cycles after the write with tx_data=0x41, then count=0 and FSM back in IDLE after busy falls.
REQ-034 Burst-write 17 bytes 0x00..0x10 with tx_busy held 1 -> full=1 at count=16, 17th byte dropped, overflow=1; release busy -> 0x00..0x0F transmitted in order.
REQ-035 tx_busy never rises after tx_we -> FSM returns to IDLE after BUSY_WAIT cycles and the next byte issues; no hang.
REQ-036 Write and pop in the same cycle at count=5 -> count stays 5 and pointers wrap correctly across index 15 to 0.
REQ-037 Assert reset_n=0 for 1 cycle during WAIT_DONE with 3 bytes queued -> all outputs at reset values, and no tx_we until a new write.
REQ-038 clr_ovf pulsed in the same cycle as a dropped write -> overflow remains 1; clr_ovf pulsed alone -> overflow=0 next cycle.
